// File: rtl/processing_unit.sv
// Datapath: four general registers, PC, IR, address register, zero flag,
// two operand buses feeding a combinational ALU and a wide writeback bus.
module pu_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] data_out
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) data_d = data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign data_out = data_q;

endmodule

module processing_unit #(
  parameter int word_size = 10,
  parameter int data_size = 8,
  parameter int op_size   = 4,
  parameter int Sel1_size = 3,
  parameter int Sel2_size = 3
) (
  output logic [word_size-1:0] instruction,
  output logic                 Zflag,
  output logic [word_size-4:0] address,
  input  logic [word_size-4:0] address_decoded,
  input  logic [data_size-1:0] constant_decoded,
  output logic [data_size-1:0] Bus_1a,
  output logic [data_size-1:0] Bus_1b,
  input  logic [word_size-1:0] mem_word,
  input  logic                 Load_R0,
  input  logic                 Load_R1,
  input  logic                 Load_R2,
  input  logic                 Load_R3,
  input  logic                 Load_PC,
  input  logic                 Inc_PC,
  input  logic [Sel1_size-1:0] Sel_Bus_1a_Mux,
  input  logic [Sel1_size-1:0] Sel_Bus_1b_Mux,
  input  logic                 Load_IR,
  input  logic                 Load_Add_R,
  input  logic                 Load_Reg_Z,
  input  logic [Sel2_size-1:0] Sel_Bus_2_Mux,
  input  logic                 clk,
  input  logic                 rst,
  output logic [data_size-1:0] R0_out,
  output logic [data_size-1:0] R1_out,
  output logic [data_size-1:0] R2_out,
  output logic [data_size-1:0] R3_out,
  output logic [data_size-1:0] PC_count
);

  wire  [word_size-1:0] Bus_2;
  logic [word_size-1:0] bus2_mux;
  logic [data_size-1:0] alu_res;
  logic [op_size-1:0]   opcode;

  logic [data_size-1:0] pc_q, pc_d;
  logic [word_size-1:0] ir_q, ir_d;
  logic [word_size-4:0] addr_q, addr_d;
  logic                 z_q, z_d;

  pu_reg #(.W(data_size)) R0 (
    .clk(clk), .rst(rst), .load(Load_R0),
    .data_in(Bus_2[data_size-1:0]), .data_out(R0_out)
  );
  pu_reg #(.W(data_size)) R1 (
    .clk(clk), .rst(rst), .load(Load_R1),
    .data_in(Bus_2[data_size-1:0]), .data_out(R1_out)
  );
  pu_reg #(.W(data_size)) R2 (
    .clk(clk), .rst(rst), .load(Load_R2),
    .data_in(Bus_2[data_size-1:0]), .data_out(R2_out)
  );
  pu_reg #(.W(data_size)) R3 (
    .clk(clk), .rst(rst), .load(Load_R3),
    .data_in(Bus_2[data_size-1:0]), .data_out(R3_out)
  );

  always_comb begin
    Bus_1a = '0;
    case (Sel_Bus_1a_Mux)
      3'd0:    Bus_1a = R0_out;
      3'd1:    Bus_1a = R1_out;
      3'd2:    Bus_1a = R2_out;
      3'd3:    Bus_1a = R3_out;
      3'd4:    Bus_1a = pc_q;
      3'd5:    Bus_1a = constant_decoded;
      default: Bus_1a = '0;
    endcase
  end

  always_comb begin
    Bus_1b = '0;
    case (Sel_Bus_1b_Mux)
      3'd0:    Bus_1b = R0_out;
      3'd1:    Bus_1b = R1_out;
      3'd2:    Bus_1b = R2_out;
      3'd3:    Bus_1b = R3_out;
      3'd4:    Bus_1b = pc_q;
      3'd5:    Bus_1b = constant_decoded;
      default: Bus_1b = '0;
    endcase
  end

  assign opcode = ir_q[word_size-1 -: op_size];

  // Carry out of add/sub/shift is intentionally dropped.
  always_comb begin
    alu_res = Bus_1a;
    case (opcode)
      4'b0000: alu_res = Bus_1a + Bus_1b;
      4'b0001: alu_res = Bus_1a - Bus_1b;
      4'b0010: alu_res = Bus_1a & Bus_1b;
      4'b0011: alu_res = Bus_1a | Bus_1b;
      4'b0100: alu_res = Bus_1a ^ Bus_1b;
      4'b0101: alu_res = ~Bus_1a;
      4'b0110: alu_res = Bus_1a << 1;
      4'b0111: alu_res = Bus_1a >> 1;
      4'b1000: alu_res = Bus_1b;
      default: alu_res = Bus_1a;
    endcase
  end

  always_comb begin
    bus2_mux = '0;
    case (Sel_Bus_2_Mux)
      3'd0:    bus2_mux[data_size-1:0] = alu_res;
      3'd1:    bus2_mux[data_size-1:0] = Bus_1a;
      3'd2:    bus2_mux = mem_word;
      3'd3:    bus2_mux[word_size-4:0] = address_decoded;
      3'd4:    bus2_mux[data_size-1:0] = constant_decoded;
      default: bus2_mux = '0;
    endcase
  end

  assign Bus_2 = bus2_mux;

  always_comb begin
    pc_d   = pc_q;
    ir_d   = ir_q;
    addr_d = addr_q;
    z_d    = z_q;
    if (Load_PC)     pc_d   = Bus_2[data_size-1:0];
    else if (Inc_PC) pc_d   = pc_q + 1'b1;
    if (Load_IR)     ir_d   = Bus_2;
    if (Load_Add_R)  addr_d = Bus_2[word_size-4:0];
    if (Load_Reg_Z)  z_d    = (alu_res == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= '0;
      ir_q   <= '0;
      addr_q <= '0;
      z_q    <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      addr_q <= addr_d;
      z_q    <= z_d;
    end
  end

  assign instruction = ir_q;
  assign Zflag       = z_q;
  assign address     = addr_q;
  assign PC_count    = pc_q;

endmodule

// File: tb/tb_processing_unit.sv
// Directed table vectors plus randomized cycles against an arithmetic model.
module tb_processing_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] instruction;
  logic       Zflag;
  logic [6:0] address;
  logic [6:0] address_decoded;
  logic [7:0] constant_decoded;
  logic [7:0] Bus_1a, Bus_1b;
  logic [9:0] mem_word;
  logic       Load_R0, Load_R1, Load_R2, Load_R3;
  logic       Load_PC, Inc_PC, Load_IR, Load_Add_R, Load_Reg_Z;
  logic [2:0] Sel_Bus_1a_Mux, Sel_Bus_1b_Mux, Sel_Bus_2_Mux;
  logic [7:0] R0_out, R1_out, R2_out, R3_out, PC_count;

  int checks = 0;
  int errors = 0;

  processing_unit dut (
    .instruction(instruction), .Zflag(Zflag), .address(address),
    .address_decoded(address_decoded),
    .constant_decoded(constant_decoded),
    .Bus_1a(Bus_1a), .Bus_1b(Bus_1b), .mem_word(mem_word),
    .Load_R0(Load_R0), .Load_R1(Load_R1), .Load_R2(Load_R2),
    .Load_R3(Load_R3), .Load_PC(Load_PC), .Inc_PC(Inc_PC),
    .Sel_Bus_1a_Mux(Sel_Bus_1a_Mux), .Sel_Bus_1b_Mux(Sel_Bus_1b_Mux),
    .Load_IR(Load_IR), .Load_Add_R(Load_Add_R), .Load_Reg_Z(Load_Reg_Z),
    .Sel_Bus_2_Mux(Sel_Bus_2_Mux), .clk(clk), .rst(rst),
    .R0_out(R0_out), .R1_out(R1_out), .R2_out(R2_out),
    .R3_out(R3_out), .PC_count(PC_count)
  );

  always #5 clk = ~clk;

  localparam logic [9:0] C_RST = 10'h200, C_R0 = 10'h100;
  localparam logic [9:0] C_R1 = 10'h080, C_R2 = 10'h040;
  localparam logic [9:0] C_R3 = 10'h020, C_PC = 10'h010;
  localparam logic [9:0] C_INC = 10'h008, C_IR = 10'h004;
  localparam logic [9:0] C_AR = 10'h002, C_Z = 10'h001;

  // check codes: 0 none, 1..4 R0..R3, 5 PC, 6 IR, 7 addr, 8 Z, 9/10 buses
  typedef struct {
    logic [9:0] ctl;
    logic [2:0] s1a, s1b, s2;
    logic [7:0] cnst;
    logic [9:0] mem;
    int ca, ea, cb, eb;
  } vec_t;

  vec_t vecs[19];

  function automatic int observe(int c);
    case (c)
      1: return int'(R0_out);
      2: return int'(R1_out);
      3: return int'(R2_out);
      4: return int'(R3_out);
      5: return int'(PC_count);
      6: return int'(instruction);
      7: return int'(address);
      8: return int'(Zflag);
      9: return int'(Bus_1a);
      10: return int'(Bus_1b);
      default: return 0;
    endcase
  endfunction

  function automatic string cname(int c);
    case (c)
      1: return "R0_out";
      2: return "R1_out";
      3: return "R2_out";
      4: return "R3_out";
      5: return "PC_count";
      6: return "instruction";
      7: return "address";
      8: return "Zflag";
      9: return "Bus_1a";
      10: return "Bus_1b";
      default: return "none";
    endcase
  endfunction

  task automatic check(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(logic [9:0] ctl, logic [2:0] s1a, logic [2:0] s1b,
                       logic [2:0] s2, logic [7:0] cnst, logic [9:0] mem,
                       logic [6:0] ad);
    rst        = ctl[9];
    Load_R0    = ctl[8];
    Load_R1    = ctl[7];
    Load_R2    = ctl[6];
    Load_R3    = ctl[5];
    Load_PC    = ctl[4];
    Inc_PC     = ctl[3];
    Load_IR    = ctl[2];
    Load_Add_R = ctl[1];
    Load_Reg_Z = ctl[0];
    Sel_Bus_1a_Mux   = s1a;
    Sel_Bus_1b_Mux   = s1b;
    Sel_Bus_2_Mux    = s2;
    constant_decoded = cnst;
    mem_word         = mem;
    address_decoded  = ad;
  endtask

  // Reference model state
  int mr[4];
  int mpc, mir, maddr, mz;

  function automatic int bus1(int sel, int cnst);
    if (sel < 4) return mr[sel];
    if (sel == 4) return mpc;
    if (sel == 5) return cnst;
    return 0;
  endfunction

  function automatic int alu(int op, int a, int b);
    case (op)
      0: return (a + b) % 256;
      1: return (a - b + 256) % 256;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return 255 - a;
      6: return (a * 2) % 256;
      7: return a / 2;
      8: return b;
      default: return a;
    endcase
  endfunction

  initial begin
    vecs[0]  = '{C_RST|10'h1ff, 0, 0, 4, 8'hAA, 10'h3ff, 1, 0, 8, 0};
    vecs[1]  = '{C_RST|10'h1ff, 0, 0, 2, 8'hAA, 10'h3ff, 5, 0, 6, 0};
    vecs[2]  = '{C_RST|10'h1ff, 0, 0, 2, 8'hAA, 10'h3ff, 7, 0, 4, 0};
    vecs[3]  = '{C_AR, 4, 0, 1, 8'h00, 10'h000, 7, 0, 5, 0};
    vecs[4]  = '{C_IR|C_INC, 0, 0, 2, 8'h00, 10'h026, 6, 'h026, 5, 1};
    vecs[5]  = '{C_R1, 0, 0, 4, 8'h01, 10'h000, 2, 1, 0, 0};
    vecs[6]  = '{C_R2, 0, 0, 4, 8'h02, 10'h000, 3, 2, 0, 0};
    vecs[7]  = '{C_R2|C_Z, 1, 2, 0, 8'h00, 10'h000, 3, 3, 8, 0};
    vecs[8]  = '{C_IR, 0, 0, 4, 8'h40, 10'h000, 6, 'h040, 0, 0};
    vecs[9]  = '{C_R1|C_R3, 0, 0, 4, 8'h05, 10'h000, 2, 5, 4, 5};
    vecs[10] = '{C_R0|C_Z, 3, 1, 0, 8'h00, 10'h000, 1, 0, 8, 1};
    vecs[11] = '{C_PC, 0, 0, 4, 8'hFF, 10'h000, 5, 255, 0, 0};
    vecs[12] = '{C_INC, 0, 0, 4, 8'hFF, 10'h000, 5, 0, 0, 0};
    vecs[13] = '{C_PC|C_INC, 0, 0, 4, 8'h10, 10'h000, 5, 16, 0, 0};
    vecs[14] = '{C_IR, 0, 0, 4, 8'h00, 10'h000, 6, 0, 0, 0};
    vecs[15] = '{C_RST|C_R2, 1, 2, 0, 8'h00, 10'h000, 3, 0, 5, 0};
    vecs[16] = '{C_R2, 0, 0, 4, 8'h33, 10'h000, 3, 'h33, 8, 0};
    vecs[17] = '{C_R2, 2, 2, 0, 8'h00, 10'h000, 3, 'h66, 9, 'h66};
    vecs[18] = '{10'h000, 6, 5, 7, 8'h77, 10'h000, 9, 0, 10, 'h77};

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].ctl, vecs[i].s1a, vecs[i].s1b, vecs[i].s2,
            vecs[i].cnst, vecs[i].mem, 7'd0);
      @(posedge clk);
      #1;
      if (vecs[i].ca != 0)
        check($sformatf("vec%0d %s", i, cname(vecs[i].ca)),
              observe(vecs[i].ca), vecs[i].ea);
      if (vecs[i].cb != 0)
        check($sformatf("vec%0d %s", i, cname(vecs[i].cb)),
              observe(vecs[i].cb), vecs[i].eb);
    end

    for (int n = 0; n < 2000; n++) begin
      int s1a, s1b, s2, cnst, mem, ad, a, b, res, w;
      logic [9:0] ctl;
      ctl = 10'($urandom);
      ctl[9] = (n == 0) || ($urandom_range(31) == 0);
      s1a  = $urandom_range(7);
      s1b  = $urandom_range(7);
      s2   = $urandom_range(7);
      cnst = $urandom_range(255);
      mem  = $urandom_range(1023);
      ad   = $urandom_range(127);
      drive(ctl, 3'(s1a), 3'(s1b), 3'(s2), 8'(cnst), 10'(mem), 7'(ad));
      #1;
      a = bus1(s1a, cnst);
      b = bus1(s1b, cnst);
      if (n > 0) begin
        check("rnd Bus_1a", int'(Bus_1a), a);
        check("rnd Bus_1b", int'(Bus_1b), b);
      end
      res = alu(mir / 64, a, b);
      case (s2)
        0: w = res;
        1: w = a;
        2: w = mem;
        3: w = ad;
        4: w = cnst;
        default: w = 0;
      endcase
      if (ctl[9]) begin
        mr = '{0, 0, 0, 0};
        mpc = 0; mir = 0; maddr = 0; mz = 0;
      end else begin
        for (int r = 0; r < 4; r++)
          if (ctl[8-r]) mr[r] = w % 256;
        if (ctl[4])      mpc = w % 256;
        else if (ctl[3]) mpc = (mpc + 1) % 256;
        if (ctl[2]) mir = w;
        if (ctl[1]) maddr = w % 128;
        if (ctl[0]) mz = (res == 0) ? 1 : 0;
      end
      @(posedge clk);
      #1;
      for (int r = 0; r < 4; r++)
        check($sformatf("rnd%0d %s", n, cname(r + 1)),
              observe(r + 1), mr[r]);
      check($sformatf("rnd%0d PC_count", n), int'(PC_count), mpc);
      check($sformatf("rnd%0d instruction", n), int'(instruction), mir);
      check($sformatf("rnd%0d address", n), int'(address), maddr);
      check($sformatf("rnd%0d Zflag", n), int'(Zflag), mz);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/processing_unit.md
PROCESSING_UNIT -- requirements
Module: processing_unit

Interface
REQ-001 Parameters SHALL be: word_size, default 10, instruction/memory word width; data_size, default 8, datapath width; op_size, default 4, opcode width; Sel1_size, default 3, Bus_1 select width; Sel2_size, default 3, Bus_2 select width.
REQ-002 Ports SHALL be, in this order: instruction, Zflag, address, address_decoded, constant_decoded, Bus_1a, Bus_1b, mem_word, Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC, Sel_Bus_1a_Mux, Sel_Bus_1b_Mux, Load_IR, Load_Add_R, Load_Reg_Z, Sel_Bus_2_Mux, clk, rst, R0_out, R1_out, R2_out, R3_out, PC_count.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 instruction  output  10  IR contents.
REQ-006 Zflag  output  1  Z register contents.
REQ-007 address  output  7  address register (Add_R) contents.
REQ-008 address_decoded  input  7  address field from control unit.
REQ-009 constant_decoded  input  8  immediate field from control unit.
REQ-010 Bus_1a, Bus_1b  output  8 each  ALU operand buses.
REQ-011 mem_word  input  10  memory read data.
REQ-012 Load_R0..Load_R3, Load_PC, Inc_PC, Load_IR, Load_Add_R, Load_Reg_Z  input  1 each  register load/increment enables.
REQ-013 Sel_Bus_1a_Mux, Sel_Bus_1b_Mux, Sel_Bus_2_Mux  input  3 each  bus source selects.
REQ-014 R0_out..R3_out, PC_count  output  8 each  register and PC contents.

Function
REQ-015 General registers SHALL be instances named R0..R3, each exposing an 8-bit output data_out; the internal 10-bit bus SHALL be a net named Bus_2.
REQ-016 Bus_1a select (combinational): 0..3 -> R0..R3, 4 -> PC, 5 -> constant_decoded, 6/7 -> 0; Bus_1b uses the same mapping.
REQ-017 Bus_2 select (combinational): 0 -> {2'b0, ALU result}, 1 -> {2'b0, Bus_1a}, 2 -> mem_word, 3 -> {3'b0, address_decoded}, 4 -> {2'b0, constant_decoded}, 5..7 -> 0.
REQ-018 ALU SHALL be combinational, a=Bus_1a, b=Bus_1b, opcode=IR[9:6], 8-bit result, carry discarded.
REQ-019 Opcodes: 0000 a+b; 0001 a-b; 0010 a&b; 0011 a|b; 0100 a^b; 0101 ~a; 0110 a<<1; 0111 a>>1 (logical); 1000 b; others a.
REQ-020 Instruction field layout: [9:6] opcode, [5:4] dest, [3:2] src1, [1:0] src2; decoding fields other than opcode is the control unit's job.
REQ-021 On a clock edge with Load_Rn=1, Rn SHALL load Bus_2[7:0]; several Load_Rn asserted together all load the same value.
REQ-022 Load_IR=1 SHALL load IR with Bus_2[9:0].
REQ-023 Load_Add_R=1 SHALL load Add_R with Bus_2[6:0].
REQ-024 PC: Load_PC=1 loads Bus_2[7:0]; else Inc_PC=1 increments by 1 with wrap 255->0; Load_PC has priority.
REQ-025 Load_Reg_Z=1 SHALL load Z with 1 when the current ALU result is 0, else 0.
REQ-026 All registers without an active enable SHALL hold; every output SHALL reflect register contents directly, so a value loaded at edge N is visible after edge N.

Reset
REQ-027 With rst=1 at a rising edge, R0..R3, PC, IR, Add_R and Z SHALL clear to 0, overriding all load/increment enables in that cycle.
REQ-028 After reset, all outputs SHALL be 0 except Bus_1a/Bus_1b, which follow their selects (0 for selects 0..4 and 6..7).

Verification
REQ-029 Reset: rst=1 for one edge with all Load_* =1 -> every register output 0, Zflag=0.
REQ-030 Fetch: PC=0, Sel1a=4, Sel2=1, Load_Add_R -> address=0; next cycle mem_word=10'b0000100110, Sel2=2, Load_IR, Inc_PC -> instruction=0x026, PC_count=1.
REQ-031 ADD: R1=1, R2=2 (loaded via Sel2=4), IR opcode 0000, Sel1a=1, Sel1b=2, Sel2=0, Load_R2, Load_Reg_Z -> R2_out=3, Zflag=0.
REQ-032 SUB to zero: R1=R3=5, opcode 0001, Sel1a=3, Sel1b=1, Sel2=0, Load_R0, Load_Reg_Z -> R0_out=0, Zflag=1.
REQ-033 PC wrap/priority: Load_PC with constant 0xFF -> PC_count=255; Inc_PC -> 0; Load_PC and Inc_PC together with constant 0x10 -> 16.
REQ-034 Reset mid-operation: during an ADD with Load_R2 asserted, rst=1 -> R2_out=0 at that edge; normal loading resumes on the edge after rst falls.
